data_port_responder: RTL and testbench
======================================

Name: data_port_responder

Overview:
- Memory-mapped responder on the CPU data port. Serves 14-bit word addresses with a scratch RAM and a small I/O register window.
- I/O window contains a TX FIFO draining to an external valid/ready stream, an RX FIFO filled from an external stream, a status register and a cycle counter.
- Sits between the CPU data port (address/write-data/write-enable out of CPU, read-data into CPU) and external stream peripherals.

Parameters:
- RAM_DEPTH, 4096: scratch RAM words at addresses 0 to RAM_DEPTH-1; at most 0x3FF0.
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..128.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- addr  in  14  word address, driven from CPU dataAddress.
- wrData  in  32  write data, driven from CPU dataOut.
- wrEn  in  1  write strobe, driven from CPU dataWrEn.
- rdData  out  32  read data, drives CPU dataIn.
- txData  out  32  TX FIFO head.
- txValid  out  1  TX FIFO non-empty.
- txReady  in  1  sink accepts txData this cycle.
- rxData  in  32  inbound word.
- rxValid  in  1  rxData valid.
- rxReady  out  1  RX FIFO can accept.

Behaviour:
- Writes: sampled at the rising edge of clk when wrEn=1. At most one write per cycle.
- Reads: rdData is combinational from addr and current registered state, with zero latency. The CPU samples it in the same cycle the address is held.
- Reads have no side effects.
- Address map:
  - 0x0000..RAM_DEPTH-1, RAM: read/write.
  - 0x3FF0, TXDATA: write pushes wrData. Read returns 0.
  - 0x3FF1, RXDATA: read returns RX head, or 0 when empty. Any write pops one entry.
  - 0x3FF2, STATUS:
    - Read bits: [0] txFull, [1] txEmpty, [2] rxFull, [3] rxEmpty, [4] txOverflow, [5] rxUnderflow, [15:8] txCount, [23:16] rxCount, all other bits 0.
    - Write: wrData[4]=1 clears txOverflow; wrData[5]=1 clears rxUnderflow (W1C).
  - 0x3FF3, CYCLES: read returns the free-running 32-bit counter. Write loads wrData.
  - Any other address: reads return 0, writes are ignored.
- RAM contents are not reset.
- TX FIFO:
  - txValid = !txEmpty. txData = head.
  - A pop occurs when txValid&&txReady at the edge.
  - A CPU push is accepted when txCount<FIFO_DEPTH, or when a pop occurs in the same cycle (full bypass).
  - Otherwise the push is dropped and txOverflow is set (sticky).
- RX FIFO:
  - rxReady = !rxFull && !rst.
  - An external push occurs when rxValid&&rxReady.
  - A CPU pop on an empty FIFO changes nothing and sets rxUnderflow (sticky).
  - A push and a pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO is visible on RXDATA the next cycle.
- Sticky flags: a set event and a W1C clear in the same cycle leave the flag set (set wins).
- Counts are clog2(FIFO_DEPTH)+1 bits, zero-extended into their status fields. Read/write pointers wrap modulo FIFO_DEPTH.
- CYCLES increments by 1 every cycle and wraps 0xFFFFFFFF->0. On a write cycle it takes wrData; that cycle's increment is discarded.
- Reset state (rst high at an edge, including mid-operation):
  - Both FIFOs empty: counts and pointers 0, txValid=0. Queued data is discarded.
  - Stickies 0, CYCLES=0.
  - rxReady is 0 while rst is high and 1 in the first cycle after rst deasserts.
  - rdData follows the map from reset state: e.g. STATUS=0x0000000A.
- No internal state machine beyond the FIFO pointer/count registers; all state updates are single-edge.

Decomposition:
- Shared package data_port_pkg holds:
  - address constants ADDR_TXDATA=14'h3FF0, ADDR_RXDATA=14'h3FF1, ADDR_STATUS=14'h3FF2, ADDR_CYCLES=14'h3FF3;
  - STATUS bit-index constants.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH):
  - ports push, pop, din, dout, count, full, empty, with synchronous active-high reset;
  - instantiated twice.
- Address decode, sticky flags, counter and RAM stay in data_port_responder.

Test Plan:
1. Reset, then read 0x3FF2 -> rdData=0x0000000A. Read 0x3FF3 one cycle after reset release -> 0x00000000. rxReady=1, txValid=0.
2. Write 0x12345678 to RAM 0x0005, then read 0x0005 -> 0x12345678 in the same cycle as addr. Write to 0x3FF8 then read 0x3FF8 -> 0.
3. txReady=0, push 17 words 1..17 to 0x3FF0 -> STATUS: txCount=16, txFull=1, txOverflow=1. Raise txReady -> txData sequence 1..16, txValid drops after 16 pops. Write 0x10 to STATUS -> txOverflow=0.
4. With TX full, push 0xAA in the same cycle as txValid&&txReady -> push accepted; txCount stays 16; 0xAA emerges last.
5. Drive rxValid with 0xC0DE0001, 0xC0DE0002 -> RXDATA reads 0xC0DE0001. Write 0x3FF1, then RXDATA=0xC0DE0002. Two more pops -> rxEmpty=1, rxUnderflow=1, RXDATA=0.
6. Write 0xFFFFFFFE to 0x3FF3 -> reads 0xFFFFFFFF next cycle, 0x00000000 the cycle after. Assert rst with both FIFOs half full -> next cycle STATUS=0x0000000A, CYCLES=0.

Source files
------------

// File: rtl/data_port_pkg.sv
// Shared address map and STATUS field layout for the CPU data-port responder.
// Constants only; no logic.
package data_port_pkg;

    localparam logic [13:0] ADDR_TXDATA = 14'h3FF0;
    localparam logic [13:0] ADDR_RXDATA = 14'h3FF1;
    localparam logic [13:0] ADDR_STATUS = 14'h3FF2;
    localparam logic [13:0] ADDR_CYCLES = 14'h3FF3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_UDF     = 5;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, head visible combinationally on dout; push/pop update on one edge.
// Pop on empty is ignored; push on full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop frees the head slot this edge, so a push into a full FIFO still fits.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/data_port_responder.sv
// CPU data-port responder: scratch RAM plus TX/RX stream FIFOs, STATUS and CYCLES registers.
// Reads are zero-latency combinational; TX drains on txValid&&txReady, RX fills while rxReady.
module data_port_responder
    import data_port_pkg::*;
#(
    parameter int RAM_DEPTH  = 4096,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] addr,
    input  logic [31:0] wrData,
    input  logic        wrEn,
    output logic [31:0] rdData,
    output logic [31:0] txData,
    output logic        txValid,
    input  logic        txReady,
    input  logic [31:0] rxData,
    input  logic        rxValid,
    output logic        rxReady
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          RAW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [13:0] RAM_LIMIT = 14'(RAM_DEPTH);

    logic [31:0]   r_ram [RAM_DEPTH];
    logic [31:0]   r_cycles;
    logic          r_tx_ovf;
    logic          r_rx_udf;

    logic          w_ram_hit;
    logic          w_wr_tx;
    logic          w_wr_rx;
    logic          w_wr_status;
    logic          w_wr_cycles;
    logic          w_tx_pop;
    logic          w_rx_push;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;
    logic [31:0]   w_rx_head;
    logic [31:0]   w_status;

    assign w_ram_hit   = (addr < RAM_LIMIT);
    assign w_wr_tx     = wrEn && (addr == ADDR_TXDATA);
    assign w_wr_rx     = wrEn && (addr == ADDR_RXDATA);
    assign w_wr_status = wrEn && (addr == ADDR_STATUS);
    assign w_wr_cycles = wrEn && (addr == ADDR_CYCLES);

    assign txValid   = !w_tx_empty;
    assign w_tx_pop  = txValid && txReady;
    assign rxReady   = !w_rx_full && !rst;
    assign w_rx_push = rxValid && rxReady;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_tx),
        .pop   (w_tx_pop),
        .din   (wrData),
        .dout  (txData),
        .count (w_tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_wr_rx),
        .din   (rxData),
        .dout  (w_rx_head),
        .count (w_rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // Sticky flags: a set event in the same cycle as a W1C clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_tx_ovf <= (w_wr_tx && w_tx_full && !w_tx_pop) ||
                        (r_tx_ovf && !(w_wr_status && wrData[ST_TX_OVF]));
            r_rx_udf <= (w_wr_rx && w_rx_empty) ||
                        (r_rx_udf && !(w_wr_status && wrData[ST_RX_UDF]));
            r_cycles <= w_wr_cycles ? wrData : r_cycles + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && w_ram_hit) r_ram[addr[RAW-1:0]] <= wrData;
    end

    always_comb begin
        w_status                                   = '0;
        w_status[ST_TX_FULL]                       = w_tx_full;
        w_status[ST_TX_EMPTY]                      = w_tx_empty;
        w_status[ST_RX_FULL]                       = w_rx_full;
        w_status[ST_RX_EMPTY]                      = w_rx_empty;
        w_status[ST_TX_OVF]                        = r_tx_ovf;
        w_status[ST_RX_UDF]                        = r_rx_udf;
        w_status[ST_TX_CNT_LSB +: 8]               = 8'(w_tx_count);
        w_status[ST_RX_CNT_LSB +: 8]               = 8'(w_rx_count);
    end

    always_comb begin
        rdData = '0;
        if (w_ram_hit) begin
            rdData = r_ram[addr[RAW-1:0]];
        end else begin
            case (addr)
                ADDR_RXDATA: rdData = w_rx_empty ? 32'd0 : w_rx_head;
                ADDR_STATUS: rdData = w_status;
                ADDR_CYCLES: rdData = r_cycles;
                default:     rdData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_port_responder.sv
// Directed bench for data_port_responder: RAM, TX/RX FIFOs, sticky flags, CYCLES and reset.
module tb_data_port_responder;
    import data_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] addr;
    logic [31:0] wrData;
    logic        wrEn;
    logic [31:0] rdData;
    logic [31:0] txData;
    logic        txValid;
    logic        txReady;
    logic [31:0] rxData;
    logic        rxValid;
    logic        rxReady;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_port_responder #(.RAM_DEPTH(4096), .FIFO_DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wrData  (wrData),
        .wrEn    (wrEn),
        .rdData  (rdData),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady),
        .rxData  (rxData),
        .rxValid (rxValid),
        .rxReady (rxReady)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        addr   = a;
        wrData = d;
        wrEn   = 1'b1;
        tick();
        wrEn   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdData, exp);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wrData = '0; wrEn = 1'b0;
        txReady = 1'b0; rxData = '0; rxValid = 1'b0;

        // 1. Reset state
        tick(); tick();
        chk("rxready_in_rst", {31'd0, rxReady}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rxready_after_rst", {31'd0, rxReady}, 32'd1);
        chk("txvalid_after_rst", {31'd0, txValid}, 32'd0);
        rd_chk("status_reset", ADDR_STATUS, 32'h0000000A);
        rd_chk("cycles_reset", ADDR_CYCLES, 32'h00000000);

        // 2. RAM and unmapped address
        wr(14'h0005, 32'h12345678);
        rd_chk("ram_rd", 14'h0005, 32'h12345678);
        wr(14'h3FF8, 32'hDEADBEEF);
        rd_chk("unmapped_rd", 14'h3FF8, 32'h00000000);
        rd_chk("txdata_rd", ADDR_TXDATA, 32'h00000000);

        // 3. TX overflow and drain
        for (int i = 1; i <= 17; i++) wr(ADDR_TXDATA, 32'(i));
        rd_chk("status_tx_ovf", ADDR_STATUS, 32'h00001019);
        txReady = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk("tx_drain_valid", {31'd0, txValid}, 32'd1);
            chk("tx_drain_data", txData, 32'(i));
            tick();
        end
        chk("tx_empty_valid", {31'd0, txValid}, 32'd0);
        wr(ADDR_STATUS, 32'h00000010);
        rd_chk("status_ovf_clr", ADDR_STATUS, 32'h0000000A);

        // 4. Full bypass: push while popping a full FIFO
        txReady = 1'b0;
        for (int i = 0; i < 16; i++) wr(ADDR_TXDATA, 32'h100 + 32'(i));
        rd_chk("status_tx_full", ADDR_STATUS, 32'h00001009);
        txReady = 1'b1;
        wr(ADDR_TXDATA, 32'h000000AA);
        txReady = 1'b0;
        rd_chk("status_bypass", ADDR_STATUS, 32'h00001009);
        txReady = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk("bypass_drain", txData, (i == 16) ? 32'hAA : 32'h100 + 32'(i));
            tick();
        end
        chk("bypass_empty", {31'd0, txValid}, 32'd0);
        txReady = 1'b0;

        // 5. RX path and underflow
        rxValid = 1'b1;
        rxData  = 32'hC0DE0001;
        rd_chk("rx_empty_before_push", ADDR_RXDATA, 32'h00000000);
        tick();
        rxData = 32'hC0DE0002;
        tick();
        rxValid = 1'b0;
        rd_chk("rx_head1", ADDR_RXDATA, 32'hC0DE0001);
        rd_chk("status_rx2", ADDR_STATUS, 32'h00020002);
        wr(ADDR_RXDATA, 32'h0);
        rd_chk("rx_head2", ADDR_RXDATA, 32'hC0DE0002);
        wr(ADDR_RXDATA, 32'h0);
        wr(ADDR_RXDATA, 32'h0);
        rd_chk("status_rx_udf", ADDR_STATUS, 32'h0000002A);
        rd_chk("rx_empty_rd", ADDR_RXDATA, 32'h00000000);
        wr(ADDR_STATUS, 32'h00000020);
        rd_chk("status_udf_clr", ADDR_STATUS, 32'h0000000A);

        // 6. CYCLES load and wrap, then reset mid-operation
        wr(ADDR_CYCLES, 32'hFFFFFFFE);
        rd_chk("cycles_loaded", ADDR_CYCLES, 32'hFFFFFFFE);
        tick();
        rd_chk("cycles_ff", ADDR_CYCLES, 32'hFFFFFFFF);
        tick();
        rd_chk("cycles_wrap", ADDR_CYCLES, 32'h00000000);

        for (int i = 0; i < 8; i++) wr(ADDR_TXDATA, 32'h200 + 32'(i));
        rxValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rxData = 32'h300 + 32'(i);
            tick();
        end
        rxValid = 1'b0;
        rd_chk("status_half", ADDR_STATUS, 32'h00080800);
        rst = 1'b1;
        #1;
        chk("rxready_rst_high", {31'd0, rxReady}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        rd_chk("status_after_rst", ADDR_STATUS, 32'h0000000A);
        rd_chk("cycles_after_rst", ADDR_CYCLES, 32'h00000000);
        chk("txvalid_after_rst2", {31'd0, txValid}, 32'd0);
        chk("rxready_after_rst2", {31'd0, rxReady}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
